// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - register-read operand collector with in-order output buffer
module operand_collector #(
  parameter int NUM_LANES         = 8,
  parameter int NUM_WARPS         = 8,
  parameter int LOG2_NUM_WARPS    = 3,
  parameter int NUM_TOTAL_THREADS = 64,
  parameter int MACHINE_WIDTH     = 32,
  parameter int LOG2_NUM_REGS     = 5,
  parameter int OPCODE_W          = 8,
  parameter int FIFO_DEPTH        = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  // upstream instruction handshake
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LOG2_NUM_WARPS-1:0]            in_warp,
  input  logic [NUM_LANES-1:0]                 in_lane_mask,
  input  logic [2:0]                           in_src_en,
  input  logic [LOG2_NUM_REGS-1:0]             in_src_addr_0,
  input  logic [LOG2_NUM_REGS-1:0]             in_src_addr_1,
  input  logic [LOG2_NUM_REGS-1:0]             in_src_addr_2,
  input  logic [LOG2_NUM_REGS-1:0]             in_dst_addr,
  input  logic [OPCODE_W-1:0]                  in_opcode,
  // register_block read request
  output logic                                 rf_block_read_en,
  output logic [LOG2_NUM_WARPS-1:0]            rf_warp_number_read,
  output logic [NUM_TOTAL_THREADS-1:0]         rf_thread_en_vector,
  output logic                                 rf_read_en_0,
  output logic                                 rf_read_en_1,
  output logic                                 rf_read_en_2,
  output logic [LOG2_NUM_REGS-1:0]             rf_read_addr_0,
  output logic [LOG2_NUM_REGS-1:0]             rf_read_addr_1,
  output logic [LOG2_NUM_REGS-1:0]             rf_read_addr_2,
  // register_block read response, valid the cycle after the request
  input  logic [NUM_LANES*MACHINE_WIDTH-1:0]   rf_read_data_0,
  input  logic [NUM_LANES*MACHINE_WIDTH-1:0]   rf_read_data_1,
  input  logic [NUM_LANES*MACHINE_WIDTH-1:0]   rf_read_data_2,
  // downstream operand handshake
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LOG2_NUM_WARPS-1:0]            out_warp,
  output logic [NUM_LANES-1:0]                 out_lane_mask,
  output logic [LOG2_NUM_REGS-1:0]             out_dst_addr,
  output logic [OPCODE_W-1:0]                  out_opcode,
  output logic [NUM_LANES*MACHINE_WIDTH-1:0]   out_operand_0,
  output logic [NUM_LANES*MACHINE_WIDTH-1:0]   out_operand_1,
  output logic [NUM_LANES*MACHINE_WIDTH-1:0]   out_operand_2
);

  localparam int VEC_W = NUM_LANES * MACHINE_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  // handshake qualifiers
  logic accept;
  logic push;
  logic pop;

  // single pending slot: metadata of the read currently in flight
  logic                      pend_valid;
  logic [LOG2_NUM_WARPS-1:0] pend_warp;
  logic [NUM_LANES-1:0]      pend_mask;
  logic [2:0]                pend_src_en;
  logic [LOG2_NUM_REGS-1:0]  pend_dst;
  logic [OPCODE_W-1:0]       pend_opcode;

  // output FIFO state
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // FIFO storage, deliberately not reset; outputs are gated by out_valid
  logic [LOG2_NUM_WARPS-1:0] mem_warp   [FIFO_DEPTH];
  logic [NUM_LANES-1:0]      mem_mask   [FIFO_DEPTH];
  logic [LOG2_NUM_REGS-1:0]  mem_dst    [FIFO_DEPTH];
  logic [OPCODE_W-1:0]       mem_opcode [FIFO_DEPTH];
  logic [VEC_W-1:0]          mem_op0    [FIFO_DEPTH];
  logic [VEC_W-1:0]          mem_op1    [FIFO_DEPTH];
  logic [VEC_W-1:0]          mem_op2    [FIFO_DEPTH];

  // returned vectors and their lane/source-masked versions
  logic [VEC_W-1:0] rd_data  [3];
  logic [VEC_W-1:0] cap_data [3];

  assign rd_data[0] = rf_read_data_0;
  assign rd_data[1] = rf_read_data_1;
  assign rd_data[2] = rf_read_data_2;

  // The pending slot reserves a FIFO entry, so admission counts it as occupied.
  // Only registered state (plus flush/reset) feeds in_ready; out_ready never does.
  assign in_ready = !reset && !flush &&
                    (({1'b0, count} + {{CNT_W{1'b0}}, pend_valid}) < DEPTH_EXT);
  assign accept   = in_valid && in_ready;
  assign push     = pend_valid && !flush;
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // read request: driven straight from the incoming instruction in an issue cycle
  always_comb begin
    rf_block_read_en    = accept;
    rf_warp_number_read = accept ? in_warp : '0;
    rf_read_en_0        = accept && in_src_en[0];
    rf_read_en_1        = accept && in_src_en[1];
    rf_read_en_2        = accept && in_src_en[2];
    rf_read_addr_0      = accept ? in_src_addr_0 : '0;
    rf_read_addr_1      = accept ? in_src_addr_1 : '0;
    rf_read_addr_2      = accept ? in_src_addr_2 : '0;
    rf_thread_en_vector = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rf_thread_en_vector[l*NUM_WARPS + w] =
          accept && in_lane_mask[l] && (in_warp == LOG2_NUM_WARPS'(w));
      end
    end
  end

  // zero inactive lanes and unused sources of the vectors returned this cycle
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cap_data[k] = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (pend_src_en[k] && pend_mask[l]) begin
          cap_data[k][(NUM_LANES-1-l)*MACHINE_WIDTH +: MACHINE_WIDTH] =
            rd_data[k][(NUM_LANES-1-l)*MACHINE_WIDTH +: MACHINE_WIDTH];
        end
      end
    end
  end

  // pending slot: lives exactly one cycle, from issue to data return
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_warp   <= '0;
      pend_mask   <= '0;
      pend_src_en <= '0;
      pend_dst    <= '0;
      pend_opcode <= '0;
    end else begin
      pend_valid <= accept && !flush;
      if (accept) begin
        pend_warp   <= in_warp;
        pend_mask   <= in_lane_mask;
        pend_src_en <= in_src_en;
        pend_dst    <= in_dst_addr;
        pend_opcode <= in_opcode;
      end
    end
  end

  // FIFO occupancy and pointers; flush wins over any push/pop in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO tail write of the collected operands plus pending metadata
  always_ff @(posedge clk) begin
    if (push) begin
      mem_warp[wr_ptr]   <= pend_warp;
      mem_mask[wr_ptr]   <= pend_mask;
      mem_dst[wr_ptr]    <= pend_dst;
      mem_opcode[wr_ptr] <= pend_opcode;
      mem_op0[wr_ptr]    <= cap_data[0];
      mem_op1[wr_ptr]    <= cap_data[1];
      mem_op2[wr_ptr]    <= cap_data[2];
    end
  end

  // head presentation, forced to zero whenever the FIFO is empty
  always_comb begin
    out_warp      = '0;
    out_lane_mask = '0;
    out_dst_addr  = '0;
    out_opcode    = '0;
    out_operand_0 = '0;
    out_operand_1 = '0;
    out_operand_2 = '0;
    if (out_valid) begin
      out_warp      = mem_warp[rd_ptr];
      out_lane_mask = mem_mask[rd_ptr];
      out_dst_addr  = mem_dst[rd_ptr];
      out_opcode    = mem_opcode[rd_ptr];
      out_operand_0 = mem_op0[rd_ptr];
      out_operand_1 = mem_op1[rd_ptr];
      out_operand_2 = mem_op2[rd_ptr];
    end
  end

endmodule
